// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the five-stage MIPS pipeline. It produces the stall
// (enable-gating) and flush (synchronous clear) controls for the stage
// registers:
//   - load-use hazards hold F/D and insert one bubble into E;
//   - taken branches and jumps clear IF/ID;
//   - a multi-cycle divide holds F/D/E while an internal FSM counts it down.
//
// Optional feature: define HAZ_BRANCH_STALL_EN to stall a branch in D until
// its comparison operands no longer depend on E, or on a load in M. Without
// it, branch_d, writereg_m and memtoreg_m are unused.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset; forces every output to 0
//   rs_d, rt_d   source registers of the instruction in D
//   branch_d     branch in D (used only with HAZ_BRANCH_STALL_EN)
//   pcsrc_d      branch taken, resolved in D
//   jump_d       jump in D
//   writereg_e   destination register of the instruction in E
//   regwrite_e   instruction in E writes a register
//   memtoreg_e   instruction in E is a load
//   writereg_m   destination register of the instruction in M
//   memtoreg_m   instruction in M is a load
//   div_start_e  divide instruction in E
//   stall_f/d/e  hold the PC, IF/ID and ID/EX registers
//   flush_d/e/m  clear IF/ID, ID/EX and EX/MEM
//   div_busy     divider FSM is in RUN
//   div_done     one-cycle pulse that latches HI/LO
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,  // RUN cycles per divide, 1..255
    parameter int CW         = 8    // counter width, 2^CW > DIV_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic       pcsrc_d,
    input  logic       jump_d,
    input  logic [4:0] writereg_e,
    input  logic       regwrite_e,
    input  logic       memtoreg_e,
    input  logic [4:0] writereg_m,
    input  logic       memtoreg_m,
    input  logic       div_start_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       div_busy,
    output logic       div_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // ------------------------------------------------------------------
    // Divide sequencer
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start_e) begin
                        state <= S_RUN;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_RUN: begin
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    else           state <= S_DONE;
                end
                // The finishing divide is still in E, so a start here is the
                // same instruction and must not relaunch the FSM.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    logic is_idle, is_run, is_done;
    logic divstall, lwstall, brstall, stall_any;

    assign is_idle = (state == S_IDLE);
    assign is_run  = (state == S_RUN);
    assign is_done = (state == S_DONE);

    // The detect cycle stalls too, so the divide never leaves E early.
    assign divstall = (is_idle & div_start_e) | is_run;

    assign lwstall = memtoreg_e & regwrite_e & (writereg_e != 5'd0) &
                     ((writereg_e == rs_d) | (writereg_e == rt_d));

`ifdef HAZ_BRANCH_STALL_EN
    logic e_match, m_match;
    assign e_match = regwrite_e & (writereg_e != 5'd0) &
                     ((writereg_e == rs_d) | (writereg_e == rt_d));
    assign m_match = memtoreg_m & (writereg_m != 5'd0) &
                     ((writereg_m == rs_d) | (writereg_m == rt_d));
    assign brstall = branch_d & (e_match | m_match);
`else
    // Forwarding into D covers every branch operand in this build.
    logic unused_branch_inputs;
    assign unused_branch_inputs = &{1'b0, branch_d, writereg_m, memtoreg_m};
    assign brstall = 1'b0;
`endif

    assign stall_any = divstall | lwstall | brstall;

    // ------------------------------------------------------------------
    // Outputs: all gated by rst so reset silences them immediately,
    // independent of the inputs still being driven.
    // ------------------------------------------------------------------
    assign stall_e  = rst & divstall;
    assign stall_f  = rst & stall_any;
    assign stall_d  = rst & stall_any;
    assign flush_m  = rst & divstall;
    // Never clear ID/EX while it holds a divide.
    assign flush_e  = rst & (lwstall | brstall) & ~divstall;
    // A stalled branch redirects only in its first unstalled cycle.
    assign flush_d  = rst & (pcsrc_d | jump_d) & ~stall_any;
    assign div_busy = rst & is_run;
    assign div_done = rst & is_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl with DIV_CYCLES=4. A behavioural model
// tracks a divide by its age in cycles since detection and derives every
// output from the hazard rules directly. Works with or without
// HAZ_BRANCH_STALL_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, writereg_e, writereg_m;
    logic       branch_d, pcsrc_d, jump_d, regwrite_e, memtoreg_e;
    logic       memtoreg_m, div_start_e;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic       div_busy, div_done;

    logic [7:0] obs;
    assign obs = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                  div_busy, div_done};

    int n_vec = 0;
    int n_err = 0;

    // -1: no divide; 1..DC: RUN cycles; DC+1: DONE cycle.
    int age = -1;

    hazard_ctrl #(.DIV_CYCLES(DC), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d),
        .jump_d(jump_d), .writereg_e(writereg_e), .regwrite_e(regwrite_e),
        .memtoreg_e(memtoreg_e), .writereg_m(writereg_m),
        .memtoreg_m(memtoreg_m), .div_start_e(div_start_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .div_busy(div_busy), .div_done(div_done)
    );

    always #5 clk = ~clk;

    // Expected outputs, packed in the same order as obs.
    function automatic logic [7:0] model_out();
        logic busy, done, divst, lw, br, st, fd, fe;
        if (!rst) return 8'h00;
        busy  = (age >= 1) && (age <= DC);
        done  = (age == DC + 1);
        divst = ((age < 0) && div_start_e) || busy;
        lw = memtoreg_e && regwrite_e && (writereg_e != 0) &&
             ((writereg_e == rs_d) || (writereg_e == rt_d));
        br = 1'b0;
`ifdef HAZ_BRANCH_STALL_EN
        br = branch_d && (
             (regwrite_e && writereg_e != 0 &&
              (writereg_e == rs_d || writereg_e == rt_d)) ||
             (memtoreg_m && writereg_m != 0 &&
              (writereg_m == rs_d || writereg_m == rt_d)));
`endif
        st = divst || lw || br;
        fe = (lw || br) && !divst;
        fd = (pcsrc_d || jump_d) && !st;
        return {st, st, divst, fd, fe, divst, busy, done};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst)          age = -1;
        else if (age < 0)  age = div_start_e ? 1 : -1;
        else if (age <= DC) age = age + 1;
        else               age = -1;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; writereg_e = 0; writereg_m = 0;
        branch_d = 0; pcsrc_d = 0; jump_d = 0; regwrite_e = 0;
        memtoreg_e = 0; memtoreg_m = 0; div_start_e = 0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        clear_inputs();
        div_start_e = 1; pcsrc_d = 1; memtoreg_e = 1; regwrite_e = 1;
        writereg_e = 3; rs_d = 3;
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++; $display("FAIL reset_forced: got %b expected %b", obs, 8'h00);
        end
        tick();
        clear_inputs();
        rst = 1;
        #1;
        exp = model_out();
        n_vec++;
        if (obs !== exp || exp !== 8'h00) begin
            n_err++; $display("FAIL reset_idle: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0] exp;
        clear_inputs();
        memtoreg_e = 1; regwrite_e = 1; writereg_e = 8; rs_d = 8;
        #1;
        exp = model_out();
        n_vec++;
        if (obs !== exp || obs !== 8'b1100_1000) begin
            n_err++; $display("FAIL load_use: got %b expected %b", obs, 8'b1100_1000);
        end
        tick();
        clear_inputs();   // the load moved on: bubble lasts one cycle
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++; $display("FAIL load_use_end: got %b expected %b", obs, 8'h00);
        end
        tick();
        memtoreg_e = 1; regwrite_e = 1; writereg_e = 0; rs_d = 0; rt_d = 0;
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++; $display("FAIL load_use_r0: got %b expected %b", obs, 8'h00);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_divide();
        logic [7:0] exp;
        int n_st = 0, n_busy = 0, n_done = 0;
        clear_inputs();
        for (int k = 0; k < DC + 2; k++) begin
            div_start_e = 1;  // held until DONE
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL divide_cyc%0d: got %b expected %b", k, obs, exp);
            end
            n_st += int'(stall_e); n_busy += int'(div_busy); n_done += int'(div_done);
            tick();
        end
        div_start_e = 0;
        n_vec++;
        if (n_st != DC + 1 || n_busy != DC || n_done != 1) begin
            n_err++;
            $display("FAIL divide_counts: got st=%0d busy=%0d done=%0d expected st=%0d busy=%0d done=1",
                     n_st, n_busy, n_done, DC + 1, DC);
        end
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++; $display("FAIL divide_after: got %b expected %b", obs, 8'h00);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        clear_inputs();
        pcsrc_d = 1;
        for (int k = 0; k < DC + 2; k++) begin
            div_start_e = 1;
            if (k >= 1 && k <= DC) begin
                memtoreg_e = 1; regwrite_e = 1; writereg_e = 9; rt_d = 9;
            end else begin
                memtoreg_e = 0; regwrite_e = 0; writereg_e = 0; rt_d = 0;
            end
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL simult_cyc%0d: got %b expected %b", k, obs, exp);
            end
            if (k == DC + 1) begin
                n_vec++;
                if (flush_d !== 1'b1) begin
                    n_err++; $display("FAIL simult_redirect: got %b expected 1", flush_d);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] exp;
        int n_done = 0;
        clear_inputs();
        div_start_e = 1;
        tick();   // RUN, cnt=DC-1
        tick();   // RUN, cnt=DC-2 (=2)
        #1;
        exp = model_out();
        n_vec++;
        if (obs !== exp || div_busy !== 1'b1) begin
            n_err++; $display("FAIL mid_run_busy: got %b expected %b", obs, exp);
        end
        #2 rst = 0;
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++; $display("FAIL mid_run_async: got %b expected %b", obs, 8'h00);
        end
        tick();
        div_start_e = 0;
        rst = 1;
        for (int k = 0; k < DC + 3; k++) begin
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL post_reset_cyc%0d: got %b expected %b", k, obs, exp);
            end
            n_done += int'(div_done);
            tick();
        end
        n_vec++;
        if (n_done != 0) begin
            n_err++; $display("FAIL abandoned_done: got %0d pulses expected 0", n_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int n_done = 0;
        clear_inputs();
        for (int k = 0; k < 2 * (DC + 2); k++) begin
            div_start_e = 1;
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL b2b_cyc%0d: got %b expected %b", k, obs, exp);
            end
            n_done += int'(div_done);
            tick();
        end
        div_start_e = 0;
        n_vec++;
        if (n_done != 2) begin
            n_err++; $display("FAIL b2b_done: got %0d pulses expected 2", n_done);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [7:0] exp;
        logic       want;
        clear_inputs();
        branch_d = 1; regwrite_e = 1; writereg_e = 5; rt_d = 5;
`ifdef HAZ_BRANCH_STALL_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        #1;
        exp = model_out();
        n_vec++;
        if (obs !== exp || stall_d !== want || flush_e !== want) begin
            n_err++;
            $display("FAIL branch_stall: got %b (stall_d=%b) expected %b (stall_d=%b)",
                     obs, stall_d, exp, want);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [7:0] exp;
        clear_inputs();
        for (int k = 0; k < 400; k++) begin
            rs_d        = 5'($urandom_range(0, 3));
            rt_d        = 5'($urandom_range(0, 3));
            writereg_e  = 5'($urandom_range(0, 3));
            writereg_m  = 5'($urandom_range(0, 3));
            branch_d    = 1'($urandom);
            pcsrc_d     = 1'($urandom);
            jump_d      = ($urandom_range(0, 7) == 0);
            regwrite_e  = 1'($urandom);
            memtoreg_e  = 1'($urandom);
            memtoreg_m  = 1'($urandom);
            div_start_e = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 49) != 0);
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL random_%0d: got %b expected %b", k, obs, exp);
            end
            tick();
        end
        rst = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_divide();
        test_simultaneous();
        test_reset_mid_run();
        test_back_to_back();
        test_branch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
